// File: rtl/fp_mant_mul_seq.sv
// Sequential shift-add significand multiplier, BPC multiplier bits per cycle.
// Produces the exact product plus 1-bit-normalised mantissa and G/R/S flags.
module fp_mant_mul_seq #(
    parameter int WIDTH = 24,
    parameter int BPC   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [2*WIDTH-1:0]   prod,
    output logic                 norm,
    output logic [WIDTH-1:0]     mant,
    output logic                 grd,
    output logic                 rnd,
    output logic                 stk,
    output logic                 out_valid,
    input  logic                 out_ready
);

    localparam int N  = WIDTH / BPC;
    localparam int CW = $clog2(N + 1);
    localparam int PW = 2 * WIDTH;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     count_q, count_d;
    logic [PW-1:0]     mcand_q, mcand_d;
    logic [WIDTH-1:0]  mplier_q, mplier_d;
    logic [PW-1:0]     acc_q, acc_d;
    logic [PW-1:0]     prod_q, prod_d;
    logic [WIDTH-1:0]  mant_q, mant_d;
    logic              norm_q, norm_d;
    logic              grd_q, grd_d;
    logic              rnd_q, rnd_d;
    logic              stk_q, stk_d;

    logic [PW-1:0]     pp;
    logic [PW-1:0]     sum;

    // Multiplicand walks left while the multiplier walks right,
    // so the partial product always lands at the right weight.
    assign pp  = mcand_q * PW'(mplier_q[BPC-1:0]);
    assign sum = acc_q + pp;

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        prod_d    = prod_q;
        mant_d    = mant_q;
        norm_d    = norm_q;
        grd_d     = grd_q;
        rnd_d     = rnd_q;
        stk_d     = stk_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;

        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    mcand_d  = PW'(a);
                    mplier_d = b;
                    acc_d    = '0;
                    count_d  = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                acc_d    = sum;
                mcand_d  = mcand_q << BPC;
                mplier_d = mplier_q >> BPC;
                count_d  = count_q + 1'b1;
                if (count_q == CW'(N - 1)) begin
                    state_d = DONE;
                    prod_d  = sum;
                    norm_d  = sum[PW-1];
                    if (sum[PW-1]) begin
                        mant_d = sum[PW-1:WIDTH];
                        grd_d  = sum[WIDTH-1];
                        rnd_d  = sum[WIDTH-2];
                        stk_d  = |sum[WIDTH-3:0];
                    end else begin
                        mant_d = sum[PW-2:WIDTH-1];
                        grd_d  = sum[WIDTH-2];
                        rnd_d  = sum[WIDTH-3];
                        stk_d  = |sum[WIDTH-4:0];
                    end
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            count_q  <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            prod_q   <= '0;
            mant_q   <= '0;
            norm_q   <= 1'b0;
            grd_q    <= 1'b0;
            rnd_q    <= 1'b0;
            stk_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            prod_q   <= prod_d;
            mant_q   <= mant_d;
            norm_q   <= norm_d;
            grd_q    <= grd_d;
            rnd_q    <= rnd_d;
            stk_q    <= stk_d;
        end
    end

    assign prod = prod_q;
    assign mant = mant_q;
    assign norm = norm_q;
    assign grd  = grd_q;
    assign rnd  = rnd_q;
    assign stk  = stk_q;

endmodule

// File: tb/tb_fp_mant_mul_seq.sv
// Randomised bench for fp_mant_mul_seq against an arithmetic reference.
// Covers defaults (BPC=1) and a BPC=4 instance.
module tb_fp_mant_mul_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic [23:0] a = '0, b = '0;
    logic        in_valid = 1'b0, out_ready = 1'b0;
    logic        in_ready, out_valid, norm, grd, rnd, stk;
    logic [47:0] prod;
    logic [23:0] mant;

    logic [23:0] a4 = '0, b4 = '0;
    logic        in_valid4 = 1'b0, out_ready4 = 1'b0;
    logic        in_ready4, out_valid4, norm4, grd4, rnd4, stk4;
    logic [47:0] prod4;
    logic [23:0] mant4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fp_mant_mul_seq u_dut (
        .clk(clk), .rst(rst), .a(a), .b(b),
        .in_valid(in_valid), .in_ready(in_ready),
        .prod(prod), .norm(norm), .mant(mant),
        .grd(grd), .rnd(rnd), .stk(stk),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    fp_mant_mul_seq #(.WIDTH(24), .BPC(4)) u_dut4 (
        .clk(clk), .rst(rst), .a(a4), .b(b4),
        .in_valid(in_valid4), .in_ready(in_ready4),
        .prod(prod4), .norm(norm4), .mant(mant4),
        .grd(grd4), .rnd(rnd4), .stk(stk4),
        .out_valid(out_valid4), .out_ready(out_ready4)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Reference: exact product, then pick the window by magnitude.
    function automatic void model(input logic [23:0] xa, input logic [23:0] xb,
                                  output logic [47:0] p, output logic n,
                                  output logic [23:0] m, output logic g,
                                  output logic r, output logic s);
        int sh;
        logic [47:0] low;
        p   = 48'(xa) * 48'(xb);
        n   = (p >= 48'h800000000000);
        sh  = n ? 24 : 23;
        m   = 24'(p >> sh);
        g   = p[sh-1];
        r   = p[sh-2];
        low = (48'd1 << (sh - 2)) - 48'd1;
        s   = (p & low) != 48'd0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [23:0] xa, input logic [23:0] xb,
                          input int stall);
        logic [47:0] ep;
        logic        en, eg, er, es;
        logic [23:0] em;
        int          n;
        model(xa, xb, ep, en, em, eg, er, es);
        a = xa;
        b = xb;
        in_valid = 1'b1;
        out_ready = 1'b0;
        n = 0;
        while (!in_ready && n < 100) begin
            tick();
            n++;
        end
        if (!in_ready) chk("accept_timeout", 0, 1);
        tick();
        in_valid = 1'b0;
        a = 24'($urandom);
        b = 24'($urandom);
        n = 0;
        while (!out_valid && n < 200) begin
            tick();
            n++;
        end
        chk("latency", n, 24);
        chk("prod", prod, ep);
        chk("norm", norm, en);
        chk("mant", mant, em);
        chk("grd", grd, eg);
        chk("rnd", rnd, er);
        chk("stk", stk, es);
        chk("busy_in_ready", in_ready, 0);
        for (int i = 0; i < stall; i++) begin
            tick();
            chk("stall_valid", out_valid, 1);
            chk("stall_in_ready", in_ready, 0);
            chk("stall_prod", prod, ep);
            chk("stall_mant", {norm, grd, rnd, stk, mant}, {en, eg, er, es, em});
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("ack_valid", out_valid, 0);
        chk("ack_in_ready", in_ready, 1);
    endtask

    task automatic run_op4(input logic [23:0] xa, input logic [23:0] xb);
        logic [47:0] ep;
        logic        en, eg, er, es;
        logic [23:0] em;
        int          n;
        model(xa, xb, ep, en, em, eg, er, es);
        a4 = xa;
        b4 = xb;
        in_valid4 = 1'b1;
        out_ready4 = 1'b0;
        n = 0;
        while (!in_ready4 && n < 100) begin
            tick();
            n++;
        end
        if (!in_ready4) chk("accept4_timeout", 0, 1);
        tick();
        in_valid4 = 1'b0;
        a4 = 24'($urandom);
        n = 0;
        while (!out_valid4 && n < 100) begin
            tick();
            n++;
        end
        chk("latency4", n, 6);
        chk("prod4", prod4, ep);
        chk("flags4", {norm4, grd4, rnd4, stk4, mant4}, {en, eg, er, es, em});
        out_ready4 = 1'b1;
        tick();
        out_ready4 = 1'b0;
        chk("ack4_in_ready", in_ready4, 1);
    endtask

    initial begin
        int n, t0, t1, acc, seen, pick;
        logic [23:0] ra, rb;

        repeat (3) tick();
        rst = 1'b0;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_prod", prod, 0);
        chk("rst_mant", {norm, grd, rnd, stk, mant}, 0);

        run_op(24'h800000, 24'h800000, 0);
        run_op(24'hFFFFFF, 24'hFFFFFF, 0);
        run_op(24'h000000, 24'hABCDEF, 0);
        run_op(24'h9A3B7C, 24'hD1E2F3, 10);

        // Back-to-back issue with the consumer always ready.
        a = 24'h123456;
        b = 24'h654321;
        in_valid = 1'b1;
        out_ready = 1'b1;
        acc = 0; t0 = 0; t1 = 0; n = 0;
        while (acc < 2 && n < 200) begin
            if (in_valid && in_ready) begin
                if (acc == 0) t0 = n;
                else t1 = n;
                acc++;
            end
            tick();
            n++;
        end
        chk("issue_interval", t1 - t0, 26);
        in_valid = 1'b0;
        n = 0;
        while (!in_ready && n < 100) begin
            tick();
            n++;
        end
        chk("drain_in_ready", in_ready, 1);
        out_ready = 1'b0;

        // Abort mid-RUN.
        a = 24'hFFFFFF;
        b = 24'hFFFFFF;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (10) tick();
        rst = 1'b1;
        out_ready = 1'b1;
        tick();
        rst = 1'b0;
        out_ready = 1'b0;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_in_ready", in_ready, 1);
        chk("abort_prod", prod, 0);
        seen = 0;
        repeat (30) begin
            tick();
            if (out_valid) seen = 1;
        end
        chk("abort_no_stale", seen, 0);
        run_op(24'hC00000, 24'hC00000, 0);

        for (int i = 0; i < 20; i++) begin
            pick = $urandom_range(0, 4);
            ra = 24'($urandom);
            rb = 24'($urandom);
            if (pick == 0) ra = 24'h000000;
            if (pick == 1) rb = 24'hFFFFFF;
            if (pick == 2) ra = ra | 24'h800000;
            run_op(ra, rb, $urandom_range(0, 3));
        end

        run_op4(24'hC00000, 24'hA00000);
        run_op4(24'hFFFFFF, 24'hFFFFFF);
        for (int i = 0; i < 6; i++) begin
            run_op4(24'($urandom), 24'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
